// File: rtl/alu_stage_if.sv
// Stage-3 -> stage-4 bus of the rv32i ALU stage: decoded instruction and
// forwarded operands in, stage-4 register contents, stall and redirect out.
interface alu_stage_if;
    // Handshake: decode_en is valid and !alu_stall is ready. The instruction moves
    // into stage 4 on a clock edge where decode_en=1, alu_stall=0 and flush=0.
    // Otherwise decode holds every stage-3 input unchanged.
    logic        decode_en;
    logic [3:0]  alu_op;
    logic        op_b_imm;
    logic        op_a_pc;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] fwd_rs1_rdata;
    logic [31:0] fwd_rs2_rdata;
    logic [4:0]  rd;
    logic        rd_w_en;
    logic        rd_late;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        alu_force_stall;
    logic        mem_stall;
    logic        flush;
    logic        alu_stall;
    logic        mem_en;
    logic [4:0]  alu_rd;
    logic        alu_rd_w_en;
    logic        alu_rd_valid;
    logic [31:0] alu_rd_data;
    logic [31:0] alu_rs2_data;
    logic        change_pc;
    logic [31:0] next_pc;

    modport master (
        output decode_en, alu_op, op_b_imm, op_a_pc, imm, pc, fwd_rs1_rdata, fwd_rs2_rdata,
               rd, rd_w_en, rd_late, branch, jump, jalr, alu_force_stall, mem_stall, flush,
        input  alu_stall, mem_en, alu_rd, alu_rd_w_en, alu_rd_valid, alu_rd_data,
               alu_rs2_data, change_pc, next_pc
    );

    modport slave (
        input  decode_en, alu_op, op_b_imm, op_a_pc, imm, pc, fwd_rs1_rdata, fwd_rs2_rdata,
               rd, rd_w_en, rd_late, branch, jump, jalr, alu_force_stall, mem_stall, flush,
        output alu_stall, mem_en, alu_rd, alu_rd_w_en, alu_rd_valid, alu_rd_data,
               alu_rs2_data, change_pc, next_pc
    );
endinterface

// File: rtl/alu_stage.sv
// rv32i stage 3 (ALU): compute, resolve branches/jumps, load the stage-4 register.
// Define ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit-per-cycle one.
module alu_stage (
    input  logic        clk,
    input  logic        rst,
    alu_stage_if.slave  bus,
    output logic        dbg_shift_state
);
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] shift_res;
    logic [31:0] alu_res;
    logic [31:0] rd_data;
    logic [31:0] target;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic        taken;
    logic        shift_busy;

    assign op_a  = bus.op_a_pc  ? bus.pc  : bus.fwd_rs1_rdata;
    assign op_b  = bus.op_b_imm ? bus.imm : bus.fwd_rs2_rdata;
    assign shamt = op_b[4:0];

`ifdef ALU_SERIAL_SHIFT_EN
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} shift_state_t;

    shift_state_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  sreg_q, sreg_d, sreg_step;
    logic         done_q, done_d;
    logic         is_shift;
    logic         start;

    assign is_shift = (bus.alu_op == 4'd7) | (bus.alu_op == 4'd8) | (bus.alu_op == 4'd9);
    // done_q keeps a finished result when mem_stall delays the capture, so the
    // still-presented instruction is not shifted a second time.
    assign start = bus.decode_en & is_shift & (shamt != 5'd0) & !done_q &
                   !bus.mem_stall & !bus.alu_force_stall & !bus.flush;

    always_comb begin
        sreg_step = {1'b0, sreg_q[31:1]};
        case (bus.alu_op)
            4'd7:    sreg_step = {sreg_q[30:0], 1'b0};
            4'd9:    sreg_step = {sreg_q[31], sreg_q[31:1]};
            default: sreg_step = {1'b0, sreg_q[31:1]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        done_d     = done_q;
        shift_busy = 1'b0;
        shift_res  = op_a;
        case (state_q)
            IDLE: begin
                if (done_q) shift_res = sreg_q;
                if (start) begin
                    state_d    = SHIFT;
                    cnt_d      = shamt;
                    sreg_d     = op_a;
                    shift_busy = 1'b1;
                end
            end
            SHIFT: begin
                sreg_d    = sreg_step;
                cnt_d     = cnt_q - 5'd1;
                shift_res = sreg_step;
                if (cnt_q == 5'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    shift_busy = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else if (!bus.mem_stall && !bus.alu_force_stall && !shift_busy) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sreg_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    assign dbg_shift_state = (state_q == SHIFT);
`else
    always_comb begin
        shift_res = op_a >> shamt;
        case (bus.alu_op)
            4'd7:    shift_res = op_a << shamt;
            4'd9:    shift_res = $unsigned($signed(op_a) >>> shamt);
            default: shift_res = op_a >> shamt;
        endcase
    end

    assign shift_busy      = 1'b0;
    assign dbg_shift_state = 1'b0;
`endif

    assign lt_s = $signed(op_a) < $signed(op_b);
    assign lt_u = op_a < op_b;
    assign eq   = op_a == op_b;

    always_comb begin
        alu_res = 32'd0;
        case (bus.alu_op)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = {31'd0, lt_s};
            4'd3:  alu_res = {31'd0, lt_u};
            4'd4:  alu_res = op_a ^ op_b;
            4'd5:  alu_res = op_a | op_b;
            4'd6:  alu_res = op_a & op_b;
            4'd7,
            4'd8,
            4'd9:  alu_res = shift_res;
            4'd10: alu_res = {31'd0, eq};
            4'd11: alu_res = {31'd0, !eq};
            4'd12: alu_res = {31'd0, lt_s};
            4'd13: alu_res = {31'd0, !lt_s};
            4'd14: alu_res = {31'd0, lt_u};
            4'd15: alu_res = {31'd0, !lt_u};
            default: alu_res = 32'd0;
        endcase
    end

    assign taken   = bus.jump | (bus.branch & alu_res[0]);
    assign target  = (bus.jump & bus.jalr) ? ((bus.fwd_rs1_rdata + bus.imm) & ~32'd1)
                                           : (bus.pc + bus.imm);
    assign rd_data = bus.jump ? (bus.pc + 32'd4) : alu_res;

    assign bus.alu_stall = !bus.flush & (bus.mem_stall | bus.alu_force_stall | shift_busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_en       <= 1'b0;
            bus.alu_rd       <= 5'd0;
            bus.alu_rd_w_en  <= 1'b0;
            bus.alu_rd_valid <= 1'b0;
            bus.alu_rd_data  <= 32'd0;
            bus.alu_rs2_data <= 32'd0;
            bus.change_pc    <= 1'b0;
            bus.next_pc      <= 32'd0;
        end else if (bus.flush) begin
            bus.mem_en    <= 1'b0;
            bus.change_pc <= 1'b0;
        end else if (bus.mem_stall) begin
            bus.change_pc <= 1'b0;
        end else if (bus.alu_force_stall || shift_busy) begin
            bus.mem_en    <= 1'b0;
            bus.change_pc <= 1'b0;
        end else begin
            // rd fields load even for a bubble; consumers qualify them with mem_en
            bus.mem_en       <= bus.decode_en;
            bus.alu_rd       <= bus.rd;
            bus.alu_rd_w_en  <= bus.rd_w_en;
            bus.alu_rd_valid <= !bus.rd_late;
            bus.alu_rd_data  <= rd_data;
            bus.alu_rs2_data <= bus.fwd_rs2_rdata;
            bus.change_pc    <= bus.decode_en & taken;
            bus.next_pc      <= target;
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// Directed bench for alu_stage: stimulus pushes expected stage-4 contents into a
// queue, a negedge monitor pops and compares on every new stage-4 capture.
module tb_alu_stage;
    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic        valid;
        logic [31:0] data;
        logic [31:0] rs2;
        logic        cpc;
        logic [31:0] npc;
    } exp_t;

`ifdef ALU_SERIAL_SHIFT_EN
    localparam bit SER = 1'b1;
`else
    localparam bit SER = 1'b0;
`endif

    logic clk;
    logic rst;
    logic dbg_state;
    logic mon_on;
    logic stall_prev;
    int   n_vec;
    int   n_err;
    logic [103:0] exp_q[$];
    exp_t last_e;

    alu_stage_if bus();

    alu_stage dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .dbg_shift_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // driver tasks
    task automatic set_instr(input logic [3:0] op, input logic a_pc, input logic b_imm,
                             input logic [31:0] imm, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic wen, input logic late,
                             input logic br, input logic jmp, input logic jalr);
        bus.decode_en     = 1'b1;
        bus.alu_op        = op;
        bus.op_a_pc       = a_pc;
        bus.op_b_imm      = b_imm;
        bus.imm           = imm;
        bus.pc            = pc;
        bus.fwd_rs1_rdata = rs1;
        bus.fwd_rs2_rdata = rs2;
        bus.rd            = rd;
        bus.rd_w_en       = wen;
        bus.rd_late       = late;
        bus.branch        = br;
        bus.jump          = jmp;
        bus.jalr          = jalr;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic wen, input logic valid,
                            input logic [31:0] data, input logic [31:0] rs2,
                            input logic cpc, input logic [31:0] npc);
        exp_t e;
        e.rd = rd; e.wen = wen; e.valid = valid; e.data = data;
        e.rs2 = rs2; e.cpc = cpc; e.npc = npc;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept(output int stalls);
        logic ok;
        ok = 1'b0;
        stalls = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!bus.alu_stall) ok = 1'b1;
            else stalls++;
        end
        check("accept_in_budget", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] op, input logic a_pc, input logic b_imm,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic late,
                       input logic br, input logic jmp, input logic jalr,
                       input logic [31:0] exp_data, input logic exp_cpc,
                       input logic [31:0] exp_npc, input int exp_stalls);
        int stalls;
        set_instr(op, a_pc, b_imm, imm, pc, rs1, rs2, rd, wen, late, br, jmp, jalr);
        push_exp(rd, wen, !late, exp_data, rs2, exp_cpc, exp_npc);
        wait_accept(stalls);
        check("stall_cycles", stalls, exp_stalls);
        bus.decode_en = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (bus.mem_en) begin
                if (!stall_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_capture", {27'd0, bus.alu_rd}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        last_e = e;
                        check("alu_rd", {27'd0, bus.alu_rd}, {27'd0, e.rd});
                        check("alu_rd_w_en", {31'd0, bus.alu_rd_w_en}, {31'd0, e.wen});
                        check("alu_rd_valid", {31'd0, bus.alu_rd_valid}, {31'd0, e.valid});
                        check("alu_rd_data", bus.alu_rd_data, e.data);
                        check("alu_rs2_data", bus.alu_rs2_data, e.rs2);
                        check("change_pc", {31'd0, bus.change_pc}, {31'd0, e.cpc});
                        if (e.cpc) check("next_pc", bus.next_pc, e.npc);
                    end
                end else begin
                    check("hold_rd_data", bus.alu_rd_data, last_e.data);
                    check("hold_rd", {27'd0, bus.alu_rd}, {27'd0, last_e.rd});
                    check("hold_rs2_data", bus.alu_rs2_data, last_e.rs2);
                    check("hold_change_pc", {31'd0, bus.change_pc}, 32'd0);
                end
            end else begin
                check("idle_change_pc", {31'd0, bus.change_pc}, 32'd0);
            end
        end
        stall_prev = bus.mem_stall;
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        mon_on = 1'b0;
        stall_prev = 1'b0;
        rst = 1'b1;
        set_instr(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.decode_en = 1'b0;
        bus.alu_force_stall = 1'b0;
        bus.mem_stall = 1'b0;
        bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_change_pc", {31'd0, bus.change_pc}, 32'd0);
        check("rst_alu_rd", {27'd0, bus.alu_rd}, 32'd0);
        check("rst_rd_w_en", {31'd0, bus.alu_rd_w_en}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.alu_rd_valid}, 32'd0);
        check("rst_rd_data", bus.alu_rd_data, 32'd0);
        check("rst_rs2_data", bus.alu_rs2_data, 32'd0);
        check("rst_next_pc", bus.next_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // op a_pc b_imm imm pc rs1 rs2 rd wen late br jmp jalr | data cpc npc stalls
        run(4'd0,  0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h2, 5'd5, 1, 0, 0, 0, 0, 32'h00000001, 0, 32'h0, 0);
        run(4'd1,  0, 0, 32'h0, 32'h0, 32'h5, 32'h7, 5'd3, 1, 1, 0, 0, 0, 32'hFFFFFFFE, 0, 32'h0, 0);
        run(4'd2,  0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd4, 1, 0, 0, 0, 0, 32'h1, 0, 32'h0, 0);
        run(4'd3,  0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1, 5'd4, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        run(4'd4,  0, 1, 32'h0F0F, 32'h0, 32'h00FF, 32'hDEAD, 5'd8, 1, 0, 0, 0, 0, 32'h0FF0, 0, 32'h0, 0);
        run(4'd5,  0, 0, 32'h0, 32'h0, 32'hF0000000, 32'hF, 5'd9, 0, 0, 0, 0, 0, 32'hF000000F, 0, 32'h0, 0);
        run(4'd6,  0, 0, 32'h0, 32'h0, 32'hFF00FF00, 32'h0F0F0F0F, 5'd10, 1, 0, 0, 0, 0, 32'h0F000F00, 0, 32'h0, 0);
        run(4'd0,  1, 1, 32'h00020000, 32'h1000, 32'h0, 32'h0, 5'd11, 1, 0, 0, 0, 0, 32'h00021000, 0, 32'h0, 0);
        run(4'd7,  0, 0, 32'h0, 32'h0, 32'h1, 32'd31, 5'd12, 1, 0, 0, 0, 0, 32'h80000000, 0, 32'h0, SER ? 31 : 0);
        run(4'd8,  0, 0, 32'h0, 32'h0, 32'h80000000, 32'h24, 5'd13, 1, 0, 0, 0, 0, 32'h08000000, 0, 32'h0, SER ? 4 : 0);
        run(4'd9,  0, 0, 32'h0, 32'h0, 32'h80000000, 32'h4, 5'd14, 1, 0, 0, 0, 0, 32'hF8000000, 0, 32'h0, SER ? 4 : 0);
        run(4'd9,  0, 0, 32'h0, 32'h0, 32'h80000000, 32'h20, 5'd15, 1, 0, 0, 0, 0, 32'h80000000, 0, 32'h0, 0);
        run(4'd10, 0, 0, 32'h20, 32'h100, 32'h7, 32'h7, 5'd0, 0, 0, 1, 0, 0, 32'h1, 1, 32'h120, 0);
        run(4'd11, 0, 0, 32'h20, 32'h100, 32'h7, 32'h7, 5'd0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        run(4'd12, 0, 0, 32'hFFFFFFF0, 32'h200, 32'hFFFFFFFB, 32'h3, 5'd0, 0, 0, 1, 0, 0, 32'h1, 1, 32'h1F0, 0);
        run(4'd13, 0, 0, 32'hFFFFFFF0, 32'h200, 32'hFFFFFFFB, 32'h3, 5'd0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        run(4'd14, 0, 0, 32'h8, 32'h300, 32'hFFFFFFFB, 32'h3, 5'd0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        run(4'd15, 0, 0, 32'h8, 32'h300, 32'hFFFFFFFB, 32'h3, 5'd0, 0, 0, 1, 0, 0, 32'h1, 1, 32'h308, 0);
        run(4'd10, 0, 0, 32'h8, 32'h300, 32'h5, 32'h5, 5'd2, 1, 0, 0, 0, 0, 32'h1, 0, 32'h0, 0);
        run(4'd0,  0, 1, 32'h0, 32'h400, 32'h203, 32'h0, 5'd1, 1, 0, 0, 1, 1, 32'h404, 1, 32'h202, 0);
        run(4'd0,  0, 1, 32'hFFFFFFFF, 32'h410, 32'h1000, 32'h0, 5'd1, 1, 0, 0, 1, 1, 32'h414, 1, 32'hFFE, 0);
        run(4'd0,  1, 1, 32'h100, 32'h500, 32'h0, 32'h0, 5'd1, 1, 0, 0, 1, 0, 32'h504, 1, 32'h600, 0);

        // load-use: one bubble, then the held instruction is captured
        set_instr(4'd0, 0, 0, 32'h0, 32'h0, 32'd10, 32'd20, 5'd6, 1, 0, 0, 0, 0);
        push_exp(5'd6, 1, 1, 32'd30, 32'd20, 0, 32'h0);
        bus.alu_force_stall = 1'b1;
        @(negedge clk);
        check("lu_alu_stall", {31'd0, bus.alu_stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.alu_force_stall = 1'b0;
        @(negedge clk);
        check("lu_bubble_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("lu_release_stall", {31'd0, bus.alu_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.decode_en = 1'b0;

        // taken branch followed by three cycles of mem_stall
        run(4'd12, 0, 0, 32'h40, 32'h700, 32'hFFFFFFFB, 32'h3, 5'd0, 0, 0, 1, 0, 0, 32'h1, 1, 32'h740, 0);
        set_instr(4'd0, 0, 0, 32'h0, 32'h0, 32'd100, 32'd23, 5'd7, 1, 0, 0, 0, 0);
        push_exp(5'd7, 1, 1, 32'd123, 32'd23, 0, 32'h0);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ms_alu_stall", {31'd0, bus.alu_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.mem_stall = 1'b0;
        @(posedge clk);
        #1;
        bus.decode_en = 1'b0;

        // mem_stall with flush in its second cycle: flush wins, held instruction dies
        run(4'd0, 0, 0, 32'h0, 32'h0, 32'h1, 32'h1, 5'd9, 1, 0, 0, 0, 0, 32'h2, 0, 32'h0, 0);
        set_instr(4'd0, 0, 0, 32'h0, 32'h0, 32'h55, 32'h1, 5'd10, 1, 0, 0, 0, 0);
        bus.mem_stall = 1'b1;
        @(negedge clk);
        check("fl_alu_stall", {31'd0, bus.alu_stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_stall_gated", {31'd0, bus.alu_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.mem_stall = 1'b0;
        bus.decode_en = 1'b0;
        @(negedge clk);
        check("fl_mem_en", {31'd0, bus.mem_en}, 32'd0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
